// File: rtl/regfile_sb_pkg.sv
// Shared RV32I core types: register index and data word definitions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32i_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [31:0]           word_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Register file bus: two read ports, issue (busy set) and writeback channels.
// Latency: reads combinational; issue/writeback take effect at the next rising edge.
// Backpressure: none; issue and writeback are single-cycle pulses, consumer stalls on busy.
// Ports: master = decode/issue/writeback side, slave = register file.
interface regfile_sb_if
    import rv32i_pkg::*;
#(
    parameter int WIDTH = 32
);
    reg_addr_t            i_rs1_addr;
    reg_addr_t            i_rs2_addr;
    logic [WIDTH-1:0]     o_rs1_data;
    logic [WIDTH-1:0]     o_rs2_data;
    logic                 o_rs1_busy;
    logic                 o_rs2_busy;
    logic                 i_issue_en;
    reg_addr_t            i_issue_rd;
    logic                 i_wb_en;
    reg_addr_t            i_wb_rd;
    logic [WIDTH-1:0]     i_wb_data;
    logic [NUM_REGS-1:0]  o_busy_mask;

    modport master (
        output i_rs1_addr, i_rs2_addr, i_issue_en, i_issue_rd,
               i_wb_en, i_wb_rd, i_wb_data,
        input  o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy, o_busy_mask
    );

    modport slave (
        input  i_rs1_addr, i_rs2_addr, i_issue_en, i_issue_rd,
               i_wb_en, i_wb_rd, i_wb_data,
        output o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy, o_busy_mask
    );

endinterface

// File: rtl/regfile_sb_read_port.sv
// One combinational read port: 32:1 data/busy select, x0 forced to zero/not busy.
// Latency: zero (purely combinational from address to data/busy).
// Backpressure: none; busy output is what the hazard logic uses to stall.
// Ports: addr in; bank/busy_vec stored state in; wb_*/issue_* for the optional
// same-cycle bypass (macro REGFILE_BYPASS_EN); data/busy out.
module regfile_read_port
    import rv32i_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  reg_addr_t                      addr,
    input  logic [NUM_REGS-1:0][WIDTH-1:0] bank,
    input  logic [NUM_REGS-1:0]            busy_vec,
    input  logic                           wb_en,
    input  reg_addr_t                      wb_rd,
    input  logic [WIDTH-1:0]               wb_data,
    input  logic                           issue_en,
    input  reg_addr_t                      issue_rd,
    output logic [WIDTH-1:0]               data,
    output logic                           busy
);

`ifdef REGFILE_BYPASS_EN
    logic wb_hit;
    assign wb_hit = wb_en && (wb_rd != '0) && (wb_rd == addr);

    always_comb begin
        data = '0;
        busy = 1'b0;
        if (addr != '0) begin
            if (wb_hit) begin
                // Writeback retires the producer this cycle, unless a newer
                // producer for the same register issues alongside it.
                data = wb_data;
                busy = issue_en && (issue_rd == addr);
            end else begin
                data = bank[addr];
                busy = busy_vec[addr];
            end
        end
    end
`else
    // Bypass inputs are only consumed by the bypass build.
    logic unused_bypass;
    assign unused_bypass = ^{wb_en, wb_rd, wb_data, issue_en, issue_rd};

    always_comb begin
        data = '0;
        busy = 1'b0;
        if (addr != '0) begin
            data = bank[addr];
            busy = busy_vec[addr];
        end
    end
`endif

endmodule

// File: rtl/regfile_sb.sv
// RV32I integer register file x1..x31 with a per-register pending-write busy bit.
// Latency: reads combinational; writes and busy updates visible the cycle after.
// Backpressure: none; busy bits tell operand selection to stall.
// Ports: i_clk, i_rst_n (async active-low), bus (regfile_sb_if.slave).
// Option: REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module regfile_sb
    import rv32i_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    regfile_sb_if.slave   bus
);

    // x0 has no storage; index 0 of the read bank is tied to zero.
    logic [WIDTH-1:0]               regs [1:NUM_REGS-1];
    logic [NUM_REGS-1:1]            busy_q;
    logic [NUM_REGS-1:0][WIDTH-1:0] bank;
    logic [NUM_REGS-1:0]            busy_vec;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.i_wb_en && (bus.i_wb_rd != '0)) begin
            regs[bus.i_wb_rd] <= bus.i_wb_data;
        end
    end

    // Set has priority over clear: an issue in the same cycle as a writeback
    // to the same rd means a newer producer is now outstanding.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (bus.i_issue_en && (bus.i_issue_rd == reg_addr_t'(i))) begin
                    busy_q[i] <= 1'b1;
                end else if (bus.i_wb_en && (bus.i_wb_rd == reg_addr_t'(i))) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bank[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            bank[i] = regs[i];
        end
    end

    assign busy_vec        = {busy_q, 1'b0};
    assign bus.o_busy_mask = busy_vec;

    regfile_read_port #(.WIDTH(WIDTH)) u_rd1 (
        .addr     (bus.i_rs1_addr),
        .bank     (bank),
        .busy_vec (busy_vec),
        .wb_en    (bus.i_wb_en),
        .wb_rd    (bus.i_wb_rd),
        .wb_data  (bus.i_wb_data),
        .issue_en (bus.i_issue_en),
        .issue_rd (bus.i_issue_rd),
        .data     (bus.o_rs1_data),
        .busy     (bus.o_rs1_busy)
    );

    regfile_read_port #(.WIDTH(WIDTH)) u_rd2 (
        .addr     (bus.i_rs2_addr),
        .bank     (bank),
        .busy_vec (busy_vec),
        .wb_en    (bus.i_wb_en),
        .wb_rd    (bus.i_wb_rd),
        .wb_data  (bus.i_wb_data),
        .issue_en (bus.i_issue_en),
        .issue_rd (bus.i_issue_rd),
        .data     (bus.o_rs2_data),
        .busy     (bus.o_rs2_busy)
    );

endmodule
